mole_scheduler: RTL and testbench
=================================

# mole_scheduler

Consumes the 16-bit pseudo-random word from the LFSR generator and turns it into game events: which hole the mole appears in, how long it stays up, and how long the gap before the next mole lasts. Sits directly downstream of the generator and upstream of the display/score logic. Reports each hit, miss and wrong-hole press as a single-cycle pulse.

## Interface
- NUM_HOLES, 8: hole count; power of two, 2..16; HOLE_W = log2(NUM_HOLES)
- UP_BASE, 16: minimum mole-up time in ticks (≥1)
- UP_STEP, 4: extra up-ticks per unit of rnd_num[11:8]
- GAP_BASE, 8: minimum gap in ticks (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rnd_num  in  16  random word from generator (changes every 16 clk)
- tick  in  1  one-cycle time-base pulse
- start  in  1  pulse: begin scheduling (IDLE only)
- stop  in  1  level/pulse: abort to IDLE from any state
- hit  in  NUM_HOLES  button press pulses, one bit per hole
- mole  out  NUM_HOLES  one-hot active hole, 0 when none
- hit_ok  out  1  pulse: correct hole pressed
- miss  out  1  pulse: mole timed out
- whiff  out  1  pulse: wrong hole pressed while mole up
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, GAP, DRAW, UP.
- IDLE: outputs 0; start → GAP, timer = GAP_BASE.
- GAP: timer decrements on tick; on tick with timer==1 → DRAW.
- DRAW: waits until rnd_num != last_rnd (freshness check); then captures rnd_num into last_rnd, hole = rnd_num[HOLE_W-1:0], up_len = UP_BASE + rnd_num[11:8]*UP_STEP, next gap = GAP_BASE + rnd_num[15:12]; → UP, mole = onehot(hole), timer = up_len.
- UP: hit[hole] set → hit_ok, mole cleared, → GAP with stored gap. Else timer expiry (tick with timer==1) → miss, mole cleared, → GAP. Else any other hit bit set → whiff, stay UP, timer keeps running.
- stop: highest priority, any state → IDLE, mole=0, no pulse.
- Arithmetic: timers 16 bit, unsigned; parameters sized so up_len and gap never overflow 16 bits.
- last_rnd resets to 16'h0000 (never produced by the LFSR), so the first DRAW completes immediately.

## Timing
- Reset: state IDLE, mole=0, hit_ok=miss=whiff=0, busy=0, timer=0, last_rnd=0.
- start → busy high next cycle.
- DRAW → mole asserted one cycle after the fresh rnd_num is seen; DRAW lasts at most 16 clk.
- hit_ok/miss/whiff registered; asserted exactly one clk, same edge mole clears.
- Same cycle hit[hole] and expiry tick: hit_ok wins, no miss.
- hit with correct bit plus other bits: hit_ok only, no whiff.
- stop with hit or expiry same cycle: stop wins, no pulse.
- start ignored outside IDLE; hit ignored outside UP.
- Gap N ticks, up time N ticks exactly (counted on tick, not clk).

## Configuration
- MOLE_NO_REPEAT_EN defined: if drawn hole equals previous hole, hole = (hole+1) mod NUM_HOLES; previous hole register reset to 0 but flagged invalid until first draw.
- Not defined: hole = raw rnd_num[HOLE_W-1:0], repeats allowed.

## Structure
- wam_pkg: state enum (IDLE, GAP, DRAW, UP), TIMER_W=16, RND_W=16.
- Sub-module mole_timer: tick-driven 16-bit down counter with load, load value, clear and expire output (expire = tick & count==1); instanced once, shared by GAP and UP.

## Test plan
- Reset mid-UP with mole=8'h04 → next edge mole=0, busy=0, state IDLE.
- start, GAP_BASE=8, rnd_num=16'h3A05 → UP after 8 ticks; mole=8'h20, up_len=16+10*4=56 ticks, next gap=8+3=11.
- In UP with hole 5, no hit → miss pulse exactly on 56th tick, mole=0, then GAP of 11 ticks.
- hit=8'h20 on same cycle as expiry tick → hit_ok=1, miss=0.
- hit=8'h01 while hole 5 up → whiff one cycle, mole stays 8'h20; then hit=8'h21 → hit_ok only.
- rnd_num held at last value in DRAW → no mole until rnd_num changes; with MOLE_NO_REPEAT_EN and repeated hole 5 → mole=8'h40.

Source files
------------

// File: rtl/wam_pkg.sv
// wam_pkg: shared types and widths for the whack-a-mole scheduler slice.
//   state_e  - scheduler FSM states (IDLE, GAP, DRAW, UP)
//   TIMER_W  - width of the tick-driven timers
//   RND_W    - width of the random word from the LFSR generator
package wam_pkg;

  localparam int TIMER_W = 16;
  localparam int RND_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    DRAW = 2'd2,
    UP   = 2'd3
  } state_e;

endpackage

// File: rtl/mole_timer.sv
// mole_timer: tick-driven down counter shared by the GAP and UP phases.
//   clk, reset  - clock, asynchronous active-high reset (count -> 0)
//   tick        - time-base pulse; the count decrements on tick while nonzero
//   load        - load load_val into the counter
//   load_val    - value to load
//   clr         - clear the counter (highest priority)
//   expire      - tick arriving while count == 1 (last tick of the interval)
module mole_timer
  import wam_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clr,
  output logic               expire
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: clear beats load, load beats decrement; parks at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {TIMER_W{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != {TIMER_W{1'b0}})) begin
      count_d = count_q - TIMER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {TIMER_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = tick & (count_q == TIMER_W'(1));

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: turns LFSR words into mole events (hole, up time, gap).
//   clk, reset      - clock, asynchronous active-high reset
//   rnd_num         - random word from the generator
//   tick            - time-base pulse; all intervals are counted in ticks
//   start / stop    - begin scheduling from IDLE / abort to IDLE (stop wins)
//   hit             - per-hole button press pulses
//   mole            - one-hot active hole, 0 when none
//   hit_ok/miss/whiff - single-cycle result pulses, registered
//   busy            - high whenever the FSM is not in IDLE
// Optional build macro MOLE_NO_REPEAT_EN: a drawn hole equal to the previous
// hole is bumped to the next hole (mod NUM_HOLES).
module mole_scheduler
  import wam_pkg::*;
#(
  parameter int NUM_HOLES = 8,
  parameter int UP_BASE   = 16,
  parameter int UP_STEP   = 4,
  parameter int GAP_BASE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RND_W-1:0]     rnd_num,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_HOLES-1:0] hit,
  output logic [NUM_HOLES-1:0] mole,
  output logic                 hit_ok,
  output logic                 miss,
  output logic                 whiff,
  output logic                 busy
);

  localparam int HOLE_W = $clog2(NUM_HOLES);

  state_e               state_q, state_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic                 hit_ok_q, hit_ok_d;
  logic                 miss_q, miss_d;
  logic                 whiff_q, whiff_d;
  logic                 busy_q, busy_d;
  logic [RND_W-1:0]     last_rnd_q, last_rnd_d;
  logic [TIMER_W-1:0]   gap_len_q, gap_len_d;

  logic                 tmr_load_s;
  logic [TIMER_W-1:0]   tmr_load_val_s;
  logic                 tmr_clr_s;
  logic                 tmr_expire_s;

  logic [HOLE_W-1:0]    raw_hole_s;
  logic [HOLE_W-1:0]    draw_hole_s;
  logic [TIMER_W-1:0]   up_len_s;
  logic [TIMER_W-1:0]   gap_s;
  logic                 draw_fire_s;
  logic                 hit_hole_s;
  logic                 hit_other_s;

  assign raw_hole_s  = rnd_num[HOLE_W-1:0];
  assign up_len_s    = TIMER_W'(UP_BASE) + TIMER_W'(rnd_num[11:8]) * TIMER_W'(UP_STEP);
  assign gap_s       = TIMER_W'(GAP_BASE) + TIMER_W'(rnd_num[15:12]);
  // A draw completes only on a word not yet consumed, so one LFSR word never
  // produces two moles.
  assign draw_fire_s = (state_q == DRAW) && !stop && (rnd_num != last_rnd_q);
  // mole_q is one-hot on the active hole, so it doubles as the hit mask.
  assign hit_hole_s  = |(hit & mole_q);
  assign hit_other_s = |(hit & ~mole_q);

`ifdef MOLE_NO_REPEAT_EN
  logic [HOLE_W-1:0] prev_hole_q, prev_hole_d;
  logic              prev_valid_q, prev_valid_d;

  // Bump a repeated hole to its neighbour once a previous draw exists.
  always_comb begin
    draw_hole_s  = raw_hole_s;
    prev_hole_d  = prev_hole_q;
    prev_valid_d = prev_valid_q;
    if (prev_valid_q && (raw_hole_s == prev_hole_q)) begin
      draw_hole_s = raw_hole_s + HOLE_W'(1);
    end else begin
      draw_hole_s = raw_hole_s;
    end
    if (draw_fire_s) begin
      prev_hole_d  = draw_hole_s;
      prev_valid_d = 1'b1;
    end else begin
      prev_hole_d  = prev_hole_q;
      prev_valid_d = prev_valid_q;
    end
  end

  // Previous-hole registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_hole_q  <= {HOLE_W{1'b0}};
      prev_valid_q <= 1'b0;
    end else begin
      prev_hole_q  <= prev_hole_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`else
  assign draw_hole_s = raw_hole_s;
`endif

  // Next-state and output logic; stop overrides every state.
  always_comb begin
    state_d        = state_q;
    mole_d         = mole_q;
    hit_ok_d       = 1'b0;
    miss_d         = 1'b0;
    whiff_d        = 1'b0;
    last_rnd_d     = last_rnd_q;
    gap_len_d      = gap_len_q;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {TIMER_W{1'b0}};
    tmr_clr_s      = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      mole_d    = {NUM_HOLES{1'b0}};
      tmr_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          mole_d = {NUM_HOLES{1'b0}};
          if (start) begin
            state_d        = GAP;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = TIMER_W'(GAP_BASE);
          end else begin
            state_d = IDLE;
          end
        end
        GAP: begin
          if (tmr_expire_s) begin
            state_d = DRAW;
          end else begin
            state_d = GAP;
          end
        end
        DRAW: begin
          if (draw_fire_s) begin
            state_d        = UP;
            last_rnd_d     = rnd_num;
            gap_len_d      = gap_s;
            mole_d         = NUM_HOLES'(1) << draw_hole_s;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = up_len_s;
          end else begin
            state_d = DRAW;
          end
        end
        UP: begin
          // Correct hole beats expiry beats wrong-hole presses.
          if (hit_hole_s) begin
            hit_ok_d       = 1'b1;
            mole_d         = {NUM_HOLES{1'b0}};
            state_d        = GAP;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = gap_len_q;
          end else if (tmr_expire_s) begin
            miss_d         = 1'b1;
            mole_d         = {NUM_HOLES{1'b0}};
            state_d        = GAP;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = gap_len_q;
          end else if (hit_other_s) begin
            whiff_d = 1'b1;
            state_d = UP;
          end else begin
            state_d = UP;
          end
        end
        default: begin
          state_d   = IDLE;
          mole_d    = {NUM_HOLES{1'b0}};
          tmr_clr_s = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mole_q     <= {NUM_HOLES{1'b0}};
      hit_ok_q   <= 1'b0;
      miss_q     <= 1'b0;
      whiff_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_rnd_q <= {RND_W{1'b0}};
      gap_len_q  <= {TIMER_W{1'b0}};
    end else begin
      state_q    <= state_d;
      mole_q     <= mole_d;
      hit_ok_q   <= hit_ok_d;
      miss_q     <= miss_d;
      whiff_q    <= whiff_d;
      busy_q     <= busy_d;
      last_rnd_q <= last_rnd_d;
      gap_len_q  <= gap_len_d;
    end
  end

  mole_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .clr      (tmr_clr_s),
    .expire   (tmr_expire_s)
  );

  assign mole   = mole_q;
  assign hit_ok = hit_ok_q;
  assign miss   = miss_q;
  assign whiff  = whiff_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed, scoreboard-checked bench for mole_scheduler.
// Expected outputs are pushed when each step is driven and popped/compared
// one cycle later (or immediately for reset checks).
module tb_mole_scheduler;

  logic        clk;
  logic        reset;
  logic [15:0] rnd_num;
  logic        tick;
  logic        start;
  logic        stop;
  logic [7:0]  hit;
  logic [7:0]  mole;
  logic        hit_ok;
  logic        miss;
  logic        whiff;
  logic        busy;

  typedef struct {
    string      tag;
    logic [11:0] val;   // {mole, hit_ok, miss, whiff, busy}
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  logic [7:0] hm_repeat;

  mole_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .rnd_num (rnd_num),
    .tick    (tick),
    .start   (start),
    .stop    (stop),
    .hit     (hit),
    .mole    (mole),
    .hit_ok  (hit_ok),
    .miss    (miss),
    .whiff   (whiff),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (vectors=%0d)", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic sb_push(input string tag, input logic [7:0] m, input logic ok,
                         input logic ms, input logic wf, input logic by);
    exp_t e;
    e.tag = tag;
    e.val = {m, ok, ms, wf, by};
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    logic [11:0] obs;
    obs = {mole, hit_ok, miss, whiff, busy};
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed mole=%h ok/miss/whiff/busy=%b required mole=%h ok/miss/whiff/busy=%b",
               e.tag, obs[11:4], obs[3:0], e.val[11:4], e.val[3:0]);
      end
    end
  endtask

  // One clock with the given inputs, then inputs return to idle.
  task automatic cyc(input logic tk, input logic [7:0] h, input logic st, input logic sp);
    tick  = tk;
    hit   = h;
    start = st;
    stop  = sp;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    hit   = 8'h00;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic step(input string tag, input logic tk, input logic [7:0] h,
                      input logic st, input logic sp, input logic [7:0] m,
                      input logic ok, input logic ms, input logic wf, input logic by);
    sb_push(tag, m, ok, ms, wf, by);
    cyc(tk, h, st, sp);
    sb_check();
  endtask

  // n ticks, each followed by a quiet cycle.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef MOLE_NO_REPEAT_EN
    hm_repeat = 8'h40;
`else
    hm_repeat = 8'h20;
`endif
    reset   = 1'b1;
    rnd_num = 16'h0000;
    tick    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    hit     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    sb_push("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_check();
    reset = 1'b0;

    // First mole: hole 5, up 56 ticks, next gap 11 ticks.
    rnd_num = 16'h3A05;
    step("start_busy", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(7);
    step("gap8_end",   1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("draw_fresh", 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(55);
    step("up_tick55",  1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    step("miss_tick56", 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step("miss_pulse_end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hit_in_gap", 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(10);
    step("gap11_end",  1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // rnd_num unchanged: DRAW must stall.
    repeat (19) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    step("draw_stale", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Same hole 5 again: up 60, gap 11.
    rnd_num = 16'h3B05;
    step("draw_repeat", 1'b0, 8'h00, 1'b0, 1'b0, hm_repeat, 1'b0, 1'b0, 1'b0, 1'b1);
    step("whiff",      1'b0, 8'h01, 1'b0, 1'b0, hm_repeat, 1'b0, 1'b0, 1'b1, 1'b1);
    step("whiff_end",  1'b0, 8'h00, 1'b0, 1'b0, hm_repeat, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hit_plus_other", 1'b0, hm_repeat | 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step("hit_ok_end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Hole 5, up 16, gap 8: hit on the expiry tick.
    rnd_num = 16'h0005;
    run_ticks(10);
    step("gap11b_end", 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("draw_h5",    1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(15);
    step("hit_at_expiry", 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Hole 2 up, then asynchronous reset mid-UP.
    rnd_num = 16'h1002;
    run_ticks(7);
    step("gap8b_end",  1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("draw_h2",    1'b0, 8'h00, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    sb_push("reset_async", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_check();
    @(posedge clk);
    #1;
    sb_push("reset_edge", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_check();
    reset = 1'b0;

    // Hole 3 up 16, then stop together with hit and expiry.
    rnd_num = 16'h2003;
    step("restart_busy", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(7);
    step("gap8c_end",  1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("draw_h3",    1'b0, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(15);
    step("stop_wins",  1'b1, 8'h08, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_after_stop", 1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    if (sb_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
